// File: rtl/merge_pipe.sv
// -----------------------------------------------------------------------------
// merge_pipe
// Three input lanes (operand A, operand B, mode) plus a valid bit travel
// through DEPTH matched register stages. A mode-selected combine stage follows,
// then a single output register. Mode 3 folds operand A into a running
// accumulator.
//
// Parameters:
//   WIDTH  data width of in_a, in_b, out and the accumulator (>= 1)
//   DEPTH  register stages on each input lane before the combine (>= 1)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   input beat qualifier
//   in_a       operand A
//   in_b       operand B
//   in_mode    0 = pass A, 1 = A+B, 2 = A-B, 3 = accumulate A
//   acc_clr    accumulator clear, applied at the output stage (not pipelined)
//   out_valid  out/out_ovf carry a new result this cycle
//   out        registered result
//   out_ovf    carry/borrow flag for the current result
//
// Build option:
//   MERGE_PIPE_SAT_EN  when defined, modes 1/3 clamp to all-ones on carry and
//                      mode 2 clamps to zero on borrow; otherwise results wrap.
// -----------------------------------------------------------------------------
module merge_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_ovf
);

    // Input lane stage registers, index 0 is the first stage.
    logic [WIDTH-1:0] a_reg     [DEPTH];
    logic [WIDTH-1:0] b_reg     [DEPTH];
    logic [1:0]       mode_reg  [DEPTH];
    logic             valid_reg [DEPTH];

    logic [WIDTH-1:0] acc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_reg[gi]     <= '0;
                        b_reg[gi]     <= '0;
                        mode_reg[gi]  <= '0;
                        valid_reg[gi] <= 1'b0;
                    end else begin
                        a_reg[gi]     <= in_a;
                        b_reg[gi]     <= in_b;
                        mode_reg[gi]  <= in_mode;
                        valid_reg[gi] <= in_valid;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_reg[gi]     <= '0;
                        b_reg[gi]     <= '0;
                        mode_reg[gi]  <= '0;
                        valid_reg[gi] <= 1'b0;
                    end else begin
                        a_reg[gi]     <= a_reg[gi-1];
                        b_reg[gi]     <= b_reg[gi-1];
                        mode_reg[gi]  <= mode_reg[gi-1];
                        valid_reg[gi] <= valid_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Combine stage on the last pipeline stage.
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic [1:0]       last_mode;
    logic             last_valid;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   sum_raw;
    logic             ovf_next;
    logic [WIDTH-1:0] res_next;

    assign last_a     = a_reg[DEPTH-1];
    assign last_b     = b_reg[DEPTH-1];
    assign last_mode  = mode_reg[DEPTH-1];
    assign last_valid = valid_reg[DEPTH-1];

    // A clear arriving with a mode-3 beat means "clear then add".
    assign acc_base = acc_clr ? '0 : acc_reg;

    always_comb begin
        sum_raw = '0;
        case (last_mode)
            2'd0:    sum_raw = {1'b0, last_a};
            2'd1:    sum_raw = {1'b0, last_a} + {1'b0, last_b};
            // Subtracting in WIDTH+1 bits leaves the borrow in the top bit.
            2'd2:    sum_raw = {1'b0, last_a} - {1'b0, last_b};
            default: sum_raw = {1'b0, acc_base} + {1'b0, last_a};
        endcase
    end

    assign ovf_next = (last_mode != 2'd0) && sum_raw[WIDTH];

`ifdef MERGE_PIPE_SAT_EN
    always_comb begin
        res_next = sum_raw[WIDTH-1:0];
        if (ovf_next) begin
            res_next = (last_mode == 2'd2) ? '0 : '1;
        end
    end
`else
    assign res_next = sum_raw[WIDTH-1:0];
`endif

    // Output register: out/out_ovf hold their value across invalid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (last_valid) begin
            out       <= res_next;
            out_ovf   <= ovf_next;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: only valid mode-3 beats load it; a lone clear zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (last_valid && (last_mode == 2'd3)) begin
            acc_reg <= res_next;
        end else if (acc_clr) begin
            acc_reg <= '0;
        end
    end

endmodule

// File: tb/tb_merge_pipe.sv
module tb_merge_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int HMAX  = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [1:0]       in_mode = '0;
    logic             acc_clr = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             out_ovf;

    int n_compared = 0;
    int n_mismatched = 0;

    merge_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out       (out),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // History of what was sampled on every rising edge, indexed by edge number.
    logic hr [HMAX];
    logic hv [HMAX];
    int   ha [HMAX];
    int   hb [HMAX];
    int   hm [HMAX];
    logic hc [HMAX];
    int   edge_n = 0;

    // Reference state: what the output should look like after each edge.
    int   m_acc = 0;
    int   m_out = 0;
    logic m_ovf = 1'b0;
    logic m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // The beat reaching the output register on edge k was sampled on edge
    // k-DEPTH; it survives only if no reset was sampled from then up to k.
    task automatic model_step();
        int k;
        int bi;
        logic alive;
        int a, b, mode, s, base, res;
        logic ovf;
        k = edge_n;
        if (hr[k]) begin
            m_acc = 0; m_out = 0; m_ovf = 1'b0; m_valid = 1'b0;
            return;
        end
        bi = k - DEPTH;
        alive = (bi >= 0);
        if (alive) begin
            alive = hv[bi];
            for (int j = bi; j < k; j++) if (hr[j]) alive = 1'b0;
        end
        if (!alive) begin
            m_valid = 1'b0;
            if (hc[k]) m_acc = 0;
            return;
        end
        a = ha[bi]; b = hb[bi]; mode = hm[bi];
        case (mode)
            0: begin s = a; ovf = 1'b0; end
            1: begin s = a + b; ovf = (s > MASK); end
            2: begin s = a - b; ovf = (a < b); end
            default: begin base = hc[k] ? 0 : m_acc; s = base + a; ovf = (s > MASK); end
        endcase
        res = s & MASK;
`ifdef MERGE_PIPE_SAT_EN
        if (ovf) res = (mode == 2) ? 0 : MASK;
`endif
        m_out = res; m_ovf = ovf; m_valid = 1'b1;
        if (mode == 3) m_acc = res;
        else if (hc[k]) m_acc = 0;
    endtask

    // One clock cycle: drive, record, let the edge happen, compare after it.
    task automatic cyc(input logic r, input logic v, input int a, input int b,
                       input int m, input logic c);
        rst = r; in_valid = v; in_a = a[WIDTH-1:0]; in_b = b[WIDTH-1:0];
        in_mode = m[1:0]; acc_clr = c;
        @(posedge clk);
        edge_n++;
        hr[edge_n] = r; hv[edge_n] = v; ha[edge_n] = a & MASK; hb[edge_n] = b & MASK;
        hm[edge_n] = m & 3; hc[edge_n] = c;
        model_step();
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("out", {24'b0, out}, m_out);
        check("out_ovf", {31'b0, out_ovf}, {31'b0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < HMAX; i++) begin
            hr[i] = 1'b1; hv[i] = 1'b0; ha[i] = 0; hb[i] = 0; hm[i] = 0; hc[i] = 1'b0;
        end
        // Reset then idle
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
        check("reset_out", {24'b0, out}, 32'h0);
        idle(10);

        // Pass mode latency
        cyc(1'b0, 1'b1, 'h5A, 'h11, 0, 1'b0);
        idle(1);
        check("pass_early_valid", {31'b0, out_valid}, 32'h0);
        idle(1);
        check("pass_valid", {31'b0, out_valid}, 32'h1);
        check("pass_out", {24'b0, out}, 32'h5A);
        idle(1);
        check("pass_hold_valid", {31'b0, out_valid}, 32'h0);
        check("pass_hold_out", {24'b0, out}, 32'h5A);

        // Add then subtract back-to-back
        cyc(1'b0, 1'b1, 'hF0, 'h20, 1, 1'b0);
        cyc(1'b0, 1'b1, 'h10, 'h30, 2, 1'b0);
        idle(1);
`ifdef MERGE_PIPE_SAT_EN
        check("add_out", {24'b0, out}, 32'hFF);
`else
        check("add_out", {24'b0, out}, 32'h10);
`endif
        check("add_ovf", {31'b0, out_ovf}, 32'h1);
        idle(1);
`ifdef MERGE_PIPE_SAT_EN
        check("sub_out", {24'b0, out}, 32'h00);
`else
        check("sub_out", {24'b0, out}, 32'hE0);
`endif
        check("sub_ovf", {31'b0, out_ovf}, 32'h1);
        check("sub_valid", {31'b0, out_valid}, 32'h1);

        // Accumulate, then clear-and-add
        cyc(1'b0, 1'b1, 'h40, 0, 3, 1'b0);
        cyc(1'b0, 1'b1, 'h40, 0, 3, 1'b0);
        cyc(1'b0, 1'b1, 'h90, 0, 3, 1'b0);
        check("acc1_out", {24'b0, out}, 32'h40);
        cyc(1'b0, 1'b1, 'h07, 0, 3, 1'b0);
        check("acc2_out", {24'b0, out}, 32'h80);
        idle(1);
`ifdef MERGE_PIPE_SAT_EN
        check("acc3_out", {24'b0, out}, 32'hFF);
`else
        check("acc3_out", {24'b0, out}, 32'h10);
`endif
        check("acc3_ovf", {31'b0, out_ovf}, 32'h1);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("accclr_out", {24'b0, out}, 32'h07);
        check("accclr_ovf", {31'b0, out_ovf}, 32'h0);

        // Reset with beats in flight
        cyc(1'b0, 1'b1, 'h01, 'h02, 1, 1'b0);
        cyc(1'b0, 1'b1, 'h03, 'h04, 1, 1'b0);
        cyc(1'b1, 1'b1, 'h05, 'h06, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("flush_valid", {31'b0, out_valid}, 32'h0);
        end
        cyc(1'b0, 1'b1, 'h01, 0, 3, 1'b0);
        idle(2);
        check("post_rst_acc", {24'b0, out}, 32'h01);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                $urandom_range(0, MASK), $urandom_range(0, MASK),
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
